// File: rtl/readout_pkg.sv
// Shared types for the readout trigger scheduler: FSM state encoding and
// the saturating shot counter helper.
package readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_BUSY  = 2'd2,
        ST_WRITE = 2'd3
    } sched_state_t;

    localparam int SHOT_W = 32;

    function automatic logic [SHOT_W-1:0] sat_inc(input logic [SHOT_W-1:0] v);
        return (&v) ? v : v + SHOT_W'(1);
    endfunction

endpackage

// File: rtl/readout_trig_sched_if.sv
// Classifier handshake and result-BRAM write port of the readout scheduler.
// master = scheduler side, slave = classifier / BRAM side.
interface readout_trig_sched_if #(
    parameter int NUM_CH         = 4,
    parameter int PRED_BITS      = 2,
    parameter int BRAM_ADDR_BITS = 14
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0]           ch_sel;
    logic                      cls_trigger;
    logic                      cls_we;
    logic [PRED_BITS-1:0]      cls_data;
    logic [BRAM_ADDR_BITS-1:0] out_ADDR;
    logic [PRED_BITS-1:0]      out_DATA;
    logic                      out_WE;

    modport master (
        output ch_sel, cls_trigger, out_ADDR, out_DATA, out_WE,
        input  cls_we, cls_data
    );

    modport slave (
        input  ch_sel, cls_trigger, out_ADDR, out_DATA, out_WE,
        output cls_we, cls_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at start_ptr
// and returns the first requester as one-hot and as an index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start_ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_vld
);

    logic [W-1:0] idx;

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = start_ptr;
        for (int i = 0; i < N; i++) begin
            idx = start_ptr + W'(i);  // N is a power of two, so this wraps naturally
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/readout_trig_sched.sv
// Shares one classifier between NUM_CH readout channels: queues shot triggers,
// serialises them round-robin, and writes each prediction to a per-channel BRAM slice.
module readout_trig_sched
    import readout_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int PRED_BITS      = 2,
    parameter int BRAM_ADDR_BITS = 14,
    parameter int TIMEOUT        = 1023
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [NUM_CH-1:0] ch_trig,
    input  logic              clear,
    readout_trig_sched_if.master bus,
    output logic [NUM_CH-1:0] ovf_sticky,
    output logic              tmo_sticky,
    output logic [SHOT_W-1:0] shot_count
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = BRAM_ADDR_BITS - CH_W;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    sched_state_t          state;
    logic [CH_W-1:0]       ch_sel_q;
    logic [CH_W-1:0]       rr_ptr;
    logic [NUM_CH-1:0]     pending;
    logic [CNT_W-1:0]      addr_cnt [NUM_CH];
    logic [TO_W-1:0]       busy_cnt;
    logic [PRED_BITS-1:0]  pred_q;
    logic                  cls_trigger_q;
    logic                  out_we_q;
    logic [BRAM_ADDR_BITS-1:0] out_addr_q;
    logic [PRED_BITS-1:0]  out_data_q;

    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_vld;
    logic [NUM_CH-1:0] grant_now;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] ovf_set;
    logic              tmo_evt;
    logic              wr_evt;

    rr_arbiter #(.N(NUM_CH)) u_rr_arbiter (
        .req       (pending),
        .start_ptr (rr_ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_vld   (gnt_vld)
    );

    // A retrigger landing on the same edge its pending bit is consumed is a new
    // shot, not an overflow; only a busy channel or an unconsumed pending drops it.
    always_comb begin
        grant_now = (state == ST_IDLE) ? gnt : '0;
        active    = '0;
        if (state != ST_IDLE) active[ch_sel_q] = 1'b1;
        ovf_set   = ch_trig & ((pending & ~grant_now) | active);
        tmo_evt   = (state == ST_BUSY) && !bus.cls_we && (busy_cnt == TO_LAST);
        wr_evt    = (state == ST_WRITE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) pending <= '0;
        else           pending <= (pending & ~grant_now) | (ch_trig & ~ovf_set);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= ST_IDLE;
            ch_sel_q      <= '0;
            rr_ptr        <= '0;
            busy_cnt      <= '0;
            pred_q        <= '0;
            cls_trigger_q <= 1'b0;
            out_we_q      <= 1'b0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
            // NOTE: addr_cnt is a small flop array, not a RAM, so it can take the async reset.
            for (int i = 0; i < NUM_CH; i++) addr_cnt[i] <= '0;
        end else begin
            cls_trigger_q <= 1'b0;
            out_we_q      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        ch_sel_q <= gnt_idx;
                        rr_ptr   <= gnt_idx + CH_W'(1);
                        state    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    cls_trigger_q <= 1'b1;
                    busy_cnt      <= '0;
                    state         <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (bus.cls_we) begin
                        pred_q <= bus.cls_data;
                        state  <= ST_WRITE;
                    end else if (busy_cnt == TO_LAST) begin
                        pred_q <= '0;
                        state  <= ST_WRITE;
                    end else begin
                        busy_cnt <= busy_cnt + TO_W'(1);
                    end
                end
                ST_WRITE: begin
                    out_we_q           <= 1'b1;
                    out_addr_q         <= {ch_sel_q, addr_cnt[ch_sel_q]};
                    out_data_q         <= pred_q;
                    addr_cnt[ch_sel_q] <= addr_cnt[ch_sel_q] + CNT_W'(1);
                    state              <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A fresh event on the clear edge survives the clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ovf_sticky <= '0;
            tmo_sticky <= 1'b0;
            shot_count <= '0;
        end else begin
            ovf_sticky <= (clear ? '0 : ovf_sticky) | ovf_set;
            tmo_sticky <= tmo_evt | (tmo_sticky & ~clear);
            if (wr_evt)     shot_count <= clear ? SHOT_W'(1) : sat_inc(shot_count);
            else if (clear) shot_count <= '0;
        end
    end

    assign bus.ch_sel      = ch_sel_q;
    assign bus.cls_trigger = cls_trigger_q;
    assign bus.out_WE      = out_we_q;
    assign bus.out_ADDR    = out_addr_q;
    assign bus.out_DATA    = out_data_q;

endmodule

// File: tb/tb_readout_trig_sched.sv
// Directed bench for readout_trig_sched: latency, round-robin order, overflow,
// timeout, address wrap and mid-shot reset, with hand-computed expectations.
module tb_readout_trig_sched;

    logic       ap_clk;
    logic       ap_rst_n;
    logic [3:0] ch_trig;
    logic       clear;
    logic [3:0] ovf_sticky;
    logic       tmo_sticky;
    logic [31:0] shot_count;

    int total = 0;
    int bad   = 0;

    readout_trig_sched_if #(.NUM_CH(4), .PRED_BITS(2), .BRAM_ADDR_BITS(14)) bus ();

    readout_trig_sched #(
        .NUM_CH(4), .PRED_BITS(2), .BRAM_ADDR_BITS(14), .TIMEOUT(1023)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ch_trig    (ch_trig),
        .clear      (clear),
        .bus        (bus),
        .ovf_sticky (ovf_sticky),
        .tmo_sticky (tmo_sticky),
        .shot_count (shot_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge ap_clk);
    endtask

    task automatic pulse_trig(input logic [3:0] m);
        ch_trig = m;
        step();
        ch_trig = '0;
    endtask

    task automatic wait_trig(input string tag);
        int w = 0;
        while (bus.cls_trigger !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        check({tag, "_trig"}, bus.cls_trigger, 1'b1);
    endtask

    task automatic wait_we(input int limit, output int lat);
        lat = 0;
        while (bus.out_WE !== 1'b1 && lat < limit) begin
            step();
            lat++;
        end
    endtask

    task automatic respond(input string tag, input logic [1:0] pred, input logic [13:0] exp_addr);
        int lat;
        bus.cls_we   = 1'b1;
        bus.cls_data = pred;
        step();
        bus.cls_we   = 1'b0;
        bus.cls_data = '0;
        wait_we(10, lat);
        check({tag, "_we"},   bus.out_WE,   1'b1);
        check({tag, "_addr"}, bus.out_ADDR, exp_addr);
        check({tag, "_data"}, bus.out_DATA, pred);
        step();
    endtask

    task automatic do_shot(input string tag, input logic [1:0] ch, input logic [1:0] pred,
                           input logic [13:0] exp_addr);
        wait_trig(tag);
        check({tag, "_sel"}, bus.ch_sel, ch);
        respond(tag, pred, exp_addr);
    endtask

    task automatic do_reset();
        step();
        #1 ap_rst_n = 1'b0;
        step();
        ap_rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        int extra;
        int wrap_err;
        int w;

        ap_rst_n     = 1'b0;
        ch_trig      = '0;
        clear        = 1'b0;
        bus.cls_we   = 1'b0;
        bus.cls_data = '0;

        // Reset state
        #2;
        check("rst_trig",  bus.cls_trigger, 1'b0);
        check("rst_we",    bus.out_WE,      1'b0);
        check("rst_addr",  bus.out_ADDR,    14'h0);
        check("rst_data",  bus.out_DATA,    2'b00);
        check("rst_sel",   bus.ch_sel,      2'd0);
        check("rst_ovf",   ovf_sticky,      4'b0);
        check("rst_tmo",   tmo_sticky,      1'b0);
        check("rst_shots", shot_count,      32'd0);
        step(2);
        ap_rst_n = 1'b1;
        step();

        // Single ch2 shot, cls_we 10 cycles after cls_trigger
        pulse_trig(4'b0100);
        check("t1_k0_trig", bus.cls_trigger, 1'b0);
        step();
        check("t1_k1_trig", bus.cls_trigger, 1'b0);
        check("t1_k1_sel",  bus.ch_sel,      2'd2);
        step();
        check("t1_k2_trig", bus.cls_trigger, 1'b1);
        step();
        check("t1_k3_trig", bus.cls_trigger, 1'b0);
        step(8);
        bus.cls_we   = 1'b1;
        bus.cls_data = 2'b10;
        step();
        bus.cls_we   = 1'b0;
        bus.cls_data = '0;
        check("t1_j0_we",  bus.out_WE, 1'b0);
        check("t1_j0_sel", bus.ch_sel, 2'd2);
        step();
        check("t1_we",    bus.out_WE,   1'b1);
        check("t1_addr",  bus.out_ADDR, 14'h2000);
        check("t1_data",  bus.out_DATA, 2'b10);
        check("t1_shots", shot_count,   32'd1);
        step();
        check("t1_we_off", bus.out_WE, 1'b0);

        // All four channels at once after reset: strict 0,1,2,3 order
        do_reset();
        check("t2_shots_rst", shot_count, 32'd0);
        pulse_trig(4'b1111);
        do_shot("t2_c0", 2'd0, 2'b01, 14'h0000);
        do_shot("t2_c1", 2'd1, 2'b10, 14'h1000);
        do_shot("t2_c2", 2'd2, 2'b11, 14'h2000);
        do_shot("t2_c3", 2'd3, 2'b00, 14'h3000);
        check("t2_ovf",   ovf_sticky, 4'b0000);
        check("t2_shots", shot_count, 32'd4);

        // Retrigger ch1 while it is busy: dropped, flagged, single write
        pulse_trig(4'b0010);
        wait_trig("t3");
        pulse_trig(4'b0010);
        respond("t3", 2'b01, 14'h1001);
        check("t3_ovf", ovf_sticky, 4'b0010);
        extra = 0;
        repeat (20) begin
            step();
            if (bus.out_WE !== 1'b0 || bus.cls_trigger !== 1'b0) extra++;
        end
        check("t3_no_second", extra, 0);
        check("t3_shots", shot_count, 32'd5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t3_clr_ovf",   ovf_sticky, 4'b0000);
        check("t3_clr_shots", shot_count, 32'd0);

        // Retrigger ch0 on the very edge its pending bit is granted: kept, no overflow
        ch_trig = 4'b0001;
        step();
        step();
        ch_trig = '0;
        do_shot("t4_a", 2'd0, 2'b11, 14'h0001);
        do_shot("t4_b", 2'd0, 2'b10, 14'h0002);
        check("t4_ovf",   ovf_sticky, 4'b0000);
        check("t4_shots", shot_count, 32'd2);

        // cls_we while idle is ignored
        bus.cls_we   = 1'b1;
        bus.cls_data = 2'b11;
        step();
        bus.cls_we   = 1'b0;
        bus.cls_data = '0;
        extra = 0;
        repeat (10) begin
            step();
            if (bus.out_WE !== 1'b0) extra++;
        end
        check("t5_stray_we", extra, 0);
        check("t5_shots", shot_count, 32'd2);

        // Classifier never answers: abort after 1023 BUSY cycles
        pulse_trig(4'b1000);
        wait_trig("t6");
        wait_we(1100, lat);
        check("t6_we",    bus.out_WE,   1'b1);
        check("t6_lat",   lat,          1024);
        check("t6_addr",  bus.out_ADDR, 14'h3001);
        check("t6_data",  bus.out_DATA, 2'b00);
        check("t6_tmo",   tmo_sticky,   1'b1);
        check("t6_shots", shot_count,   32'd3);
        step();
        pulse_trig(4'b1000);
        do_shot("t6_next", 2'd3, 2'b01, 14'h3002);
        check("t6_tmo_hold", tmo_sticky, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t6_clr_tmo",   tmo_sticky, 1'b0);
        check("t6_clr_shots", shot_count, 32'd0);

        // 4096 shots on ch0 fill its slice, the 4097th wraps to 0x0000
        do_reset();
        wrap_err = 0;
        for (int s = 0; s < 4096; s++) begin
            pulse_trig(4'b0001);
            w = 0;
            while (bus.cls_trigger !== 1'b1 && w < 10) begin
                step();
                w++;
            end
            bus.cls_we   = 1'b1;
            bus.cls_data = s[1:0];
            step();
            bus.cls_we   = 1'b0;
            w = 0;
            while (bus.out_WE !== 1'b1 && w < 10) begin
                step();
                w++;
            end
            if (bus.out_WE !== 1'b1 || bus.out_ADDR !== 14'(s) || bus.out_DATA !== s[1:0])
                wrap_err++;
            step();
        end
        check("t7_fill_errs", wrap_err, 0);
        check("t7_shots_4096", shot_count, 32'd4096);
        pulse_trig(4'b0001);
        do_shot("t7_wrap", 2'd0, 2'b11, 14'h0000);
        check("t7_shots_4097", shot_count, 32'd4097);
        pulse_trig(4'b0100);
        do_shot("t7_c2", 2'd2, 2'b01, 14'h2000);

        // Reset while ch1 is BUSY: everything clears at once, shot is lost
        pulse_trig(4'b0010);
        wait_trig("t8");
        pulse_trig(4'b0010);
        step(2);
        #1 ap_rst_n = 1'b0;
        #1;
        check("t8_trig",  bus.cls_trigger, 1'b0);
        check("t8_we",    bus.out_WE,      1'b0);
        check("t8_addr",  bus.out_ADDR,    14'h0);
        check("t8_data",  bus.out_DATA,    2'b00);
        check("t8_sel",   bus.ch_sel,      2'd0);
        check("t8_ovf",   ovf_sticky,      4'b0);
        check("t8_shots", shot_count,      32'd0);
        step();
        ap_rst_n = 1'b1;
        bus.cls_we   = 1'b1;
        bus.cls_data = 2'b10;
        step();
        bus.cls_we   = 1'b0;
        bus.cls_data = '0;
        extra = 0;
        repeat (30) begin
            step();
            if (bus.out_WE !== 1'b0 || bus.cls_trigger !== 1'b0) extra++;
        end
        check("t8_quiet", extra, 0);
        pulse_trig(4'b0010);
        do_shot("t8_new", 2'd1, 2'b10, 14'h1000);
        check("t8_new_shots", shot_count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
